// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation-control stage.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    DRAIN,
    REQ,
    PAUSED,
    HALTED
  } state_t;

  localparam logic KIND_STOP   = 1'b0;
  localparam logic KIND_FINISH = 1'b1;

  // Width of a down-counter able to hold n, never narrower than one bit.
  function automatic int unsigned drain_w(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sim_event_edge.sv
// Registered rising-edge detector for a level flag.
module sim_event_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember the level seen on the previous edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_q <= 1'b0;
    else     level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/sim_finish_ctrl.sv
// Turns DUT finish/stop flags into a single held host request, with a
// fixed drain period, DUT freeze and event-cycle capture.
module sim_finish_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned CYCLE_W      = 32,
  parameter int unsigned CODE_W       = 8,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_in,
  input  logic               stop_in,
  input  logic [CODE_W-1:0]  exit_code_in,
  output logic               run_en,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic               req_valid,
  output logic               req_kind,
  output logic [CODE_W-1:0]  req_code,
  output logic [CYCLE_W-1:0] req_cycle,
  input  logic               req_ready,
  input  logic               resume,
  output logic               finished
);

  localparam int unsigned    DCW        = drain_w(DRAIN_CYCLES);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DRAIN_CYCLES);

  state_t         state;
  logic [DCW-1:0] drain_cnt;
  logic           done_ev;
  logic           stop_ev;

  sim_event_edge u_done_edge (
    .clk   (clk),
    .rst   (rst),
    .level (done_in),
    .rise  (done_ev)
  );

  sim_event_edge u_stop_edge (
    .clk   (clk),
    .rst   (rst),
    .level (stop_in),
    .rise  (stop_ev)
  );

  // Count cycles in which the DUT advanced, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_count <= '0;
    end else if (run_en && (cycle_count != '1)) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  // Control FSM: capture event, drain, present request, then pause or halt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      run_en    <= 1'b1;
      req_valid <= 1'b0;
      req_kind  <= KIND_STOP;
      req_code  <= '0;
      req_cycle <= '0;
      finished  <= 1'b0;
      drain_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (done_ev || stop_ev) begin
            req_kind  <= done_ev ? KIND_FINISH : KIND_STOP;
            req_code  <= exit_code_in;
            req_cycle <= cycle_count;
            if (DRAIN_CYCLES == 0) begin
              state     <= REQ;
              run_en    <= 1'b0;
              req_valid <= 1'b1;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        DRAIN: begin
          // A finish overrides a pending stop without restarting the drain.
          if (done_ev && (req_kind == KIND_STOP)) begin
            req_kind  <= KIND_FINISH;
            req_code  <= exit_code_in;
            req_cycle <= cycle_count;
          end
          if (drain_cnt == DCW'(1)) begin
            state     <= REQ;
            run_en    <= 1'b0;
            req_valid <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        REQ: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            if (req_kind == KIND_FINISH) begin
              state    <= HALTED;
              finished <= 1'b1;
            end else begin
              state <= PAUSED;
            end
          end
        end
        PAUSED: begin
          if (resume) begin
            state  <= RUN;
            run_en <= 1'b1;
          end
        end
        HALTED: begin
        end
        default: begin
          state  <= RUN;
          run_en <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_finish_ctrl.sv
// Self-checking bench for sim_finish_ctrl: behavioural model + scoreboard
// for the main instance, directed checks for a narrow, zero-drain instance.
`timescale 1ns/1ps
module tb_sim_finish_ctrl;

  localparam int unsigned DR = 2;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_in, stop_in, req_ready, resume;
  logic [7:0]  exit_code_in;
  logic        run_en, req_valid, req_kind, finished;
  logic [31:0] cycle_count, req_cycle;
  logic [7:0]  req_code;

  logic        b_done, b_stop, b_ready, b_resume;
  logic [7:0]  b_code;
  logic        b_run_en, b_valid, b_kind, b_finished;
  logic [3:0]  b_count, b_rcycle;
  logic [7:0]  b_rcode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sim_finish_ctrl #(.CYCLE_W(32), .CODE_W(8), .DRAIN_CYCLES(DR)) u_dut (
    .clk(clk), .rst(rst), .done_in(done_in), .stop_in(stop_in),
    .exit_code_in(exit_code_in), .run_en(run_en), .cycle_count(cycle_count),
    .req_valid(req_valid), .req_kind(req_kind), .req_code(req_code),
    .req_cycle(req_cycle), .req_ready(req_ready), .resume(resume),
    .finished(finished)
  );

  sim_finish_ctrl #(.CYCLE_W(4), .CODE_W(8), .DRAIN_CYCLES(0)) u_w4 (
    .clk(clk), .rst(rst), .done_in(b_done), .stop_in(b_stop),
    .exit_code_in(b_code), .run_en(b_run_en), .cycle_count(b_count),
    .req_valid(b_valid), .req_kind(b_kind), .req_code(b_rcode),
    .req_cycle(b_rcycle), .req_ready(b_ready), .resume(b_resume),
    .finished(b_finished)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         kind;
    logic [7:0] code;
    longint     cycle;
  } req_t;

  req_t       sb[$];
  bit         m_wait, m_paused, m_halted, m_drain, m_dl, m_sl, m_kind;
  int         m_left;
  longint     m_cnt, m_cycle;
  logic [7:0] m_code;

  task automatic model_reset();
    m_wait = 0; m_paused = 0; m_halted = 0; m_drain = 0;
    m_dl = 0; m_sl = 0; m_kind = 0; m_left = 0;
    m_cnt = 0; m_cycle = 0; m_code = '0;
    sb.delete();
  endtask

  task automatic fire();
    m_wait = 1;
    sb.push_back('{m_kind, m_code, m_cycle});
  endtask

  task automatic model_step();
    bit d_ev, s_ev, en;
    d_ev = done_in && !m_dl;
    s_ev = stop_in && !m_sl;
    en   = !(m_wait || m_paused || m_halted);
    if (m_halted) begin
    end else if (m_wait) begin
      if (req_ready) begin
        m_wait = 0;
        if (m_kind) m_halted = 1; else m_paused = 1;
      end
    end else if (m_paused) begin
      if (resume) m_paused = 0;
    end else if (m_drain) begin
      if (d_ev && !m_kind) begin
        m_kind = 1; m_code = exit_code_in; m_cycle = m_cnt;
      end
      m_left--;
      if (m_left == 0) begin
        m_drain = 0;
        fire();
      end
    end else if (d_ev || s_ev) begin
      m_kind = d_ev; m_code = exit_code_in; m_cycle = m_cnt;
      if (DR == 0) fire();
      else begin
        m_drain = 1; m_left = DR;
      end
    end
    if (en && m_cnt < CNT_MAX) m_cnt++;
    m_dl = done_in;
    m_sl = stop_in;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("run_en", run_en, !(m_wait || m_paused || m_halted));
      check("cycle_count", cycle_count, m_cnt);
      check("req_valid", req_valid, m_wait);
      check("finished", finished, m_halted);
      if (req_valid && sb.size() > 0) begin
        check("sb_kind", req_kind, sb[0].kind);
        check("sb_code", req_code, sb[0].code);
        check("sb_cycle", req_cycle, sb[0].cycle);
        if (req_ready) void'(sb.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1; done_in = 0; stop_in = 0; req_ready = 0; resume = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask

  initial begin
    rst = 1; done_in = 0; stop_in = 0; req_ready = 0; resume = 0;
    exit_code_in = '0;
    b_done = 0; b_stop = 0; b_ready = 0; b_resume = 0; b_code = '0;
    step(2);
    rst = 0;

    // reset state
    check("rst_run_en", run_en, 1);
    check("rst_count", cycle_count, 0);
    check("rst_valid", req_valid, 0);
    check("rst_kind", req_kind, 0);
    check("rst_code", req_code, 0);
    check("rst_cycle", req_cycle, 0);
    check("rst_finished", finished, 0);

    // finish with drain of 2
    step(5);
    done_in = 1; exit_code_in = 8'h2A;
    step(2);
    check("fin_valid_early", req_valid, 0);
    step(1);
    check("fin_valid", req_valid, 1);
    check("fin_kind", req_kind, 1);
    check("fin_code", req_code, 8'h2A);
    check("fin_cycle", req_cycle, 5);
    check("fin_count", cycle_count, 8);
    check("fin_run_en", run_en, 0);
    req_ready = 1;
    step(1);
    req_ready = 0;
    check("fin_finished", finished, 1);
    check("fin_valid_drop", req_valid, 0);
    step(3);
    check("fin_count_frozen", cycle_count, 8);

    // stop, backpressure, resume
    do_reset();
    step(10);
    stop_in = 1; exit_code_in = 8'h07;
    step(3);
    check("stop_valid", req_valid, 1);
    check("stop_kind", req_kind, 0);
    check("stop_cycle", req_cycle, 10);
    step(5);
    check("bp_valid", req_valid, 1);
    check("bp_code", req_code, 8'h07);
    check("bp_cycle", req_cycle, 10);
    check("bp_count", cycle_count, 13);
    req_ready = 1;
    step(1);
    req_ready = 0;
    check("pause_valid", req_valid, 0);
    check("pause_run_en", run_en, 0);
    check("pause_finished", finished, 0);
    step(4);
    check("pause_count", cycle_count, 13);
    resume = 1;
    step(1);
    resume = 0;
    check("resume_run_en", run_en, 1);
    step(8);
    check("held_stop_no_req", req_valid, 0);
    check("resume_count", cycle_count, 21);

    // simultaneous rise: finish wins
    do_reset();
    step(3);
    done_in = 1; stop_in = 1; exit_code_in = 8'h11;
    step(3);
    check("sim_valid", req_valid, 1);
    check("sim_kind", req_kind, 1);
    check("sim_cycle", req_cycle, 3);
    req_ready = 1;
    step(1);
    req_ready = 0;
    check("sim_finished", finished, 1);
    step(3);

    // stop upgraded by finish while draining
    do_reset();
    step(4);
    stop_in = 1; exit_code_in = 8'h33;
    step(1);
    done_in = 1; exit_code_in = 8'h55;
    step(1);
    check("upg_valid_early", req_valid, 0);
    step(1);
    check("upg_valid", req_valid, 1);
    check("upg_kind", req_kind, 1);
    check("upg_code", req_code, 8'h55);
    check("upg_cycle", req_cycle, 5);
    check("upg_count", cycle_count, 7);
    req_ready = 1;
    step(1);
    req_ready = 0;
    check("upg_finished", finished, 1);
    step(5);

    // reset while a request is pending; flag high at release is an event
    do_reset();
    step(2);
    done_in = 1; exit_code_in = 8'h09;
    step(3);
    check("rreq_valid", req_valid, 1);
    rst = 1;
    #1;
    check("rreq_valid_cleared", req_valid, 0);
    check("rreq_count_cleared", cycle_count, 0);
    check("rreq_run_en", run_en, 1);
    check("rreq_kind_cleared", req_kind, 0);
    @(posedge clk);
    #1 rst = 0;
    step(3);
    check("rel_valid", req_valid, 1);
    check("rel_cycle", req_cycle, 0);
    req_ready = 1;
    step(1);
    req_ready = 0;

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) done_in = ~done_in;
      if ($urandom_range(0, 14) == 0) stop_in = ~stop_in;
      exit_code_in = 8'($urandom);
      req_ready    = ($urandom_range(0, 2) != 0);
      resume       = ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 249) == 0);
      step(1);
    end
    rst = 0;

    // narrow counter saturation and zero-drain latency
    do_reset();
    step(20);
    check("w4_saturate", b_count, 15);
    check("w4_run_en", b_run_en, 1);
    b_done = 1; b_code = 8'h5A;
    check("w4_valid_before", b_valid, 0);
    step(1);
    check("w4_valid", b_valid, 1);
    check("w4_kind", b_kind, 1);
    check("w4_code", b_rcode, 8'h5A);
    check("w4_cycle", b_rcycle, 15);
    check("w4_frozen", b_run_en, 0);
    b_ready = 1;
    step(1);
    b_ready = 0;
    check("w4_finished", b_finished, 1);
    check("w4_count_held", b_count, 15);
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sim_finish_ctrl.md
# sim_finish_ctrl

Simulation-control stage that consumes a DUT's completion and stop flags (e.g. a counter's sticky `done`) and turns them into a single, held request to the host runtime for `$finish`/`$stop` handling. It detects flag rising edges, lets the design drain for a fixed number of cycles, freezes the DUT via a run-enable, and records the cycle at which the event fired. It sits directly downstream of synthesizable testbench DUTs and upstream of the host event interface.

## Interface
- `CYCLE_W`, 32, width of cycle counter and reported cycle
- `CODE_W`, 8, width of exit code
- `DRAIN_CYCLES`, 2, cycles DUT keeps running after the event before the request (0 allowed)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `done_in`  in  1  finish flag from DUT (level; event = rising edge)
- `stop_in`  in  1  stop flag from DUT (level; event = rising edge)
- `exit_code_in`  in  CODE_W  exit code, sampled with the finish/stop event
- `run_en`  out  1  DUT clock enable; 1 = DUT advances
- `cycle_count`  out  CYCLE_W  cycles elapsed with `run_en`=1
- `req_valid`  out  1  host request pending
- `req_kind`  out  1  0 = stop, 1 = finish
- `req_code`  out  CODE_W  captured exit code
- `req_cycle`  out  CYCLE_W  `cycle_count` value in the event cycle
- `req_ready`  in  1  host accepts request
- `resume`  in  1  host pulse: continue after stop
- `finished`  out  1  sticky, simulation ended

## Operation
- States: RUN, DRAIN, REQ, PAUSED, HALTED. `run_en`=1 in RUN and DRAIN, 0 otherwise.
- Edge detect: registered `done_q`, `stop_q` updated every cycle; event = `x_in & ~x_q`.
- RUN: finish event → capture kind=1, code, cycle; stop event → kind=0. Both same cycle → finish wins. Next state DRAIN (load drain counter with DRAIN_CYCLES), or REQ if DRAIN_CYCLES=0.
- DRAIN: counter decrements each cycle; at 1 → REQ. Further stop events ignored. A finish event while draining a stop upgrades kind to 1 and recaptures code/cycle; the drain counter is not reloaded.
- REQ: `req_valid`=1; `req_kind/code/cycle` stable until `req_valid & req_ready`. On handshake: kind=1 → HALTED; kind=0 → PAUSED. `req_valid` drops the next cycle.
- PAUSED: `resume`=1 → RUN. Flags still high at resume produce no new event (edge-based). Events arriving in PAUSED are not latched.
- HALTED: terminal until `rst`; `finished`=1; all inputs ignored.
- `cycle_count` increments on every edge where `run_en`=1; saturates at all-ones (no wrap).
- `resume` outside PAUSED ignored; `req_ready` outside REQ ignored.

## Timing
- Reset values: state RUN, `run_en`=1, `cycle_count`=0, `req_valid`=0, `req_kind`=0, `req_code`=0, `req_cycle`=0, `finished`=0, `done_q`=`stop_q`=0.
- A flag already high at reset release is an event on the first edge.
- Event sampled at edge E → `req_valid` high after edge E+DRAIN_CYCLES+1; `run_en` low from the same point.
- DUT receives exactly DRAIN_CYCLES enabled cycles after the event cycle.
- `req_ready` high in the first REQ cycle → handshake in that cycle; zero-wait accepted.
- `finished` asserts the cycle after the finish handshake.
- `resume` in PAUSED → `run_en`=1 the next cycle.
- `rst` mid-DRAIN/REQ/PAUSED: immediate return to reset values, pending request discarded.

## Structure
- Package `sim_ctrl_pkg`: state enum (RUN, DRAIN, REQ, PAUSED, HALTED), constants KIND_STOP=0, KIND_FINISH=1.
- Sub-module `sim_event_edge`: registered rising-edge detector, instantiated for `done_in` and `stop_in`.
- Drain counter width: $clog2(DRAIN_CYCLES+1), minimum 1.

## Test plan
- Finish, DRAIN_CYCLES=2: `done_in` rises with `cycle_count`=5 and code 0x2A → `req_valid` 3 edges later; kind=1, code=0x2A, cycle=5; `cycle_count` frozen at 8; `req_ready`=1 → `finished`=1 the next cycle.
- Stop/resume: `stop_in` rises at cycle 10 → kind=0, cycle=10; handshake → PAUSED, `run_en`=0; `resume` pulse → `run_en`=1; `stop_in` held high causes no new request.
- Simultaneous `done_in`/`stop_in` rise → single request, kind=1.
- Stop then finish during DRAIN → single request, kind=1, cycle = finish event cycle; no second request.
- Backpressure: `req_ready` low for 5 cycles → fields stable, `cycle_count` unchanged; DRAIN_CYCLES=0 → `req_valid` one edge after event.
- `rst` asserted in REQ → `req_valid`=0 and `cycle_count`=0 immediately; CYCLE_W=4 run of 20 enabled cycles → `cycle_count` saturates at 15.
